mem_read_scheduler: RTL

Schedules the shared AXI read channel between the core's read requesters: index 0 is the I-cache, index 1 is the D-cache, and index 2 is the instruction stream buffer. It sits between those requesters and the AXI read-address and read-data pins. Only one burst is in flight at a time. Arbitration is fixed-priority for the D-cache, with anti-starvation aging for the other requesters and round-robin among them.

---
 rtl/mem_read_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_read_scheduler.sv
// Shared AXI read-channel scheduler: I-cache, D-cache and stream buffer
// requesters, one burst in flight, D-cache priority with aging and RR.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_addr/req_len      packed per-requester burst requests
//   req_ready                       one-hot accept pulse (IDLE only)
//   resp_valid/resp_last/resp_data  beats forwarded to the burst owner
//   AR*/R*                          AXI read address / read data pins
//   busy                            scheduler not idle
//   id_err                          sticky: beat seen with a foreign RID
module mem_read_scheduler #(
  parameter int MASTERS      = 3,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int PRIO_MASTER  = 1,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MASTERS-1:0]      req_valid,
  input  logic [MASTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [MASTERS*4-1:0]    req_len,
  output logic [MASTERS-1:0]      req_ready,
  output logic [MASTERS-1:0]      resp_valid,
  output logic                    resp_last,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [3:0]              ARID,
  output logic [3:0]              ARLEN,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic                    RLAST,
  input  logic [3:0]              RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    busy,
  output logic                    id_err
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t                state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         rr_next;
  logic [CW-1:0]         wait_cnt [MASTERS];
  logic [3:0]            ar_id;
  logic [3:0]            ar_len;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  busy_q;
  logic                  id_err_q;

  logic                  grant;
  logic [IW-1:0]         win;
  logic                  found;
  logic [IW-1:0]         rr_win;
  logic [IW-1:0]         sel;
  int                    idx;
  logic                  id_ok;
  logic                  beat_ok;

  // Winner: starved (lowest index) > priority master > round robin.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_win = '0;
    sel    = '0;
    idx    = 0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (req_valid[i] && wait_cnt[i] == LIMIT) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
    if (!found && req_valid[PRIO_MASTER]) begin
      win   = IW'(PRIO_MASTER);
      found = 1'b1;
    end
    // Scan downwards so the entry closest to rr_ptr is kept last.
    for (int k = MASTERS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      sel = IW'(idx);
      if (req_valid[sel]) rr_win = sel;
    end
    if (!found) win = rr_win;
  end

  assign grant = rst_n && (state == IDLE) && (|req_valid);

  assign rr_next = (int'(win) == MASTERS - 1) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < MASTERS; i++) begin
      req_ready[i] = grant && (win == IW'(i));
    end
  end

  assign id_ok   = (RID == ar_id);
  assign beat_ok = (state == DATA) && RVALID && id_ok;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < MASTERS; i++) begin
      resp_valid[i] = beat_ok && (ar_id == 4'(i));
    end
  end

  assign resp_last = beat_ok && RLAST;
  assign resp_data = RDATA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ar_id     <= '0;
      ar_len    <= '0;
      ar_addr   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state     <= ADDR;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            ar_id     <= 4'(win);
            ar_addr   <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            ar_len    <= req_len[int'(win)*4 +: 4];
            rr_ptr    <= rr_next;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            state     <= DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        DATA: begin
          if (RVALID) begin
            if (!id_ok) begin
              id_err_q <= 1'b1;
            end else if (RLAST) begin
              state    <= IDLE;
              rready_q <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Aging: count cycles a request waits unserved, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MASTERS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != LIMIT) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ARVALID = arvalid_q;
  assign ARID    = ar_id;
  assign ARLEN   = ar_len;
  assign ARADDR  = ar_addr;
  assign RREADY  = rready_q;
  assign busy    = busy_q;
  assign id_err  = id_err_q;

endmodule
